awg_cmd_ctrl: RTL and testbench
===============================

# awg_cmd_ctrl

Frame-level command controller for the arbitrary waveform generator's UART control path. It gates the byte receiver and assembles 4-byte command frames from received bytes. It validates each frame and decodes the command fields. Accepted settings (waveform type, frequency set, amplitude code) are presented to the waveform datapath through a valid/ack handshake, and the receiver is stalled until the datapath takes the new settings.

## Interface
Parameters:
- HEADER, 8'hAA, frame start byte.
- TIMEOUT_CYCLES, 500_000, maximum inter-byte gap in clocks (10 ms at 50 MHz). Must be ≥ 2.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- RX_Done_Sig  in  1  one-cycle pulse from the byte receiver; RX_Data is valid in the same cycle.
- RX_Data  in  8  received byte.
- RX_En_Sig  out  1  receiver enable.
- Cfg_Ack  in  1  datapath has latched the settings.
- Cfg_Valid  out  1  new settings pending.
- Wave_Type  out  2  decoded waveform type.
- Freq_Set  out  4  decoded frequency set.
- Amp_Code  out  8  amplitude code.
- Frame_Err  out  1  one-cycle pulse on a rejected or timed-out frame.
- Err_Cnt  out  8  saturating count of Frame_Err pulses.

## Operation
- The frame format is HEADER, CMD, AMP, SUM. A frame is accepted when SUM == HEADER ^ CMD ^ AMP and CMD[7:6] == 2'b00.
- CMD decode (bit-reversed fields):
  - Wave_Type[1] = CMD[0], Wave_Type[0] = CMD[1].
  - Freq_Set[3] = CMD[2], Freq_Set[2] = CMD[3], Freq_Set[1] = CMD[4], Freq_Set[0] = CMD[5].
- The FSM has five states: HDR (reset state), CMD, AMP, SUM, PEND.
  - HDR: a byte equal to HEADER moves to CMD. Any other byte is discarded silently, with no error.
  - CMD: capture the byte into a shadow register and move to AMP.
  - AMP: capture the byte into a shadow register and move to SUM.
  - SUM: on a valid frame, load the outputs from the shadows, set Cfg_Valid and move to PEND. On an invalid frame, pulse Frame_Err and return to HDR. A SUM byte equal to HEADER is not re-interpreted as a start byte.
  - PEND: hold until Cfg_Ack, then clear Cfg_Valid and return to HDR.
- RX_En_Sig is registered. It is 1 in HDR, CMD, AMP and SUM, and 0 in PEND.
- RX_Done_Sig arriving in PEND is ignored. Cfg_Ack while Cfg_Valid = 0 is ignored.
- Gap timer: cleared on every RX_Done_Sig and held at 0 in HDR and PEND. In CMD, AMP or SUM, when the count reaches TIMEOUT_CYCLES-1 with no byte:
  - pulse Frame_Err;
  - return to HDR;
  - discard the shadows.
- Err_Cnt increments on every Frame_Err pulse and saturates at 255.
- Wave_Type, Freq_Set and Amp_Code change only on an accepted frame. They hold their values through rejected frames.

## Timing
- Reset values:
  - RX_En_Sig = 0, Cfg_Valid = 0, Frame_Err = 0, Err_Cnt = 0.
  - Wave_Type = 0, Freq_Set = 0, Amp_Code = 0.
  - FSM = HDR, timer = 0.
- RX_En_Sig rises at the first CLK edge after RSTn deasserts.
- Latency: if the SUM-byte RX_Done_Sig is sampled at edge N, then after edge N the outputs are updated, Cfg_Valid = 1, RX_En_Sig = 0 and the FSM is in PEND.
- Cfg_Ack sampled high at edge M gives Cfg_Valid = 0, RX_En_Sig = 1 and FSM = HDR after edge M. Cfg_Ack may already be high in the first PEND cycle; the minimum PEND residency is 1 cycle.
- Frame_Err is high for exactly one cycle, after the edge that detected the error. Err_Cnt reflects the increment in that same cycle.
- If RX_Done_Sig and timeout expiry occur in the same cycle, the byte wins and the timer clears.
- Reset asserted mid-frame or in PEND returns immediately to reset values. No partial settings are retained.

## Structure
- Package awg_cmd_pkg contains:
  - FSM state encoding (3-bit enum);
  - default HEADER constant;
  - CMD field bit positions;
  - a checksum function returning the XOR of its three operands.
- One sub-module, awg_gap_timer, handles gap detection:
  - parameter TIMEOUT_CYCLES; inputs clear, run; output expire (single pulse);
  - counter width is $clog2(TIMEOUT_CYCLES).
- The FSM, shadow registers and output registers stay in awg_cmd_ctrl.

## Test plan
- Valid frame: AA, 0x15, 0x80, 0x3F → after the SUM edge, Wave_Type = 2'b10, Freq_Set = 4'b1010, Amp_Code = 0x80, Cfg_Valid = 1, RX_En_Sig = 0. Ack 3 cycles later → Cfg_Valid = 0, RX_En_Sig = 1.
- Bad checksum: AA, 0x15, 0x80, 0x00 → Frame_Err pulses once, Err_Cnt = 1, outputs unchanged, FSM back to HDR.
- Reserved bits: AA, 0xC0, 0x00, 0x6A (checksum correct) → rejected; Frame_Err pulses and Err_Cnt increments.
- Timeout: AA, 0x15, then no byte for TIMEOUT_CYCLES (TIMEOUT_CYCLES = 16 in the bench) → Frame_Err pulses after the 16th idle cycle. A following complete valid frame is accepted.
- Noise and stall:
  - 0x00, 0x55 before AA → ignored with no error; the frame is accepted.
  - Bytes pulsed on RX_Done_Sig during PEND are ignored, and settings stay stable until Ack.
- Reset and saturation:
  - Assert RSTn low in AMP → all outputs at reset values. A frame after release is accepted.
  - 300 bad frames → Err_Cnt = 255.

Source files
------------

// File: rtl/awg_cmd_pkg.sv
// Shared types and constants for the AWG UART command controller.
// Holds the FSM encoding, the default frame header, CMD field positions and the checksum function.
package awg_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_CMD  = 3'd1,
    ST_AMP  = 3'd2,
    ST_SUM  = 3'd3,
    ST_PEND = 3'd4
  } awg_state_t;

  localparam logic [7:0] AWG_HEADER_DEFAULT = 8'hAA;

  // CMD fields are bit-reversed relative to the outputs they drive.
  localparam int CMD_WT1_BIT = 0;
  localparam int CMD_WT0_BIT = 1;
  localparam int CMD_FS3_BIT = 2;
  localparam int CMD_FS2_BIT = 3;
  localparam int CMD_FS1_BIT = 4;
  localparam int CMD_FS0_BIT = 5;
  localparam int CMD_RSV_LO  = 6;
  localparam int CMD_RSV_HI  = 7;

  function automatic logic [7:0] awg_checksum(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/awg_cmd_if.sv
// Byte-receiver and settings bus between the command controller (master) and its environment (slave).
interface awg_cmd_if;

  // Settings handshake: Cfg_Valid rises with new settings and stays high, with the
  // settings frozen, until Cfg_Ack is sampled high; the transfer completes on that edge.
  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_En_Sig;
  logic       Cfg_Ack;
  logic       Cfg_Valid;
  logic [1:0] Wave_Type;
  logic [3:0] Freq_Set;
  logic [7:0] Amp_Code;
  logic       Frame_Err;
  logic [7:0] Err_Cnt;

  modport master (
    input  RX_Done_Sig, RX_Data, Cfg_Ack,
    output RX_En_Sig, Cfg_Valid, Wave_Type, Freq_Set, Amp_Code, Frame_Err, Err_Cnt
  );

  modport slave (
    output RX_Done_Sig, RX_Data, Cfg_Ack,
    input  RX_En_Sig, Cfg_Valid, Wave_Type, Freq_Set, Amp_Code, Frame_Err, Err_Cnt
  );

endinterface

// File: rtl/awg_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while run is high and pulses expire
// on the cycle the count reaches TIMEOUT_CYCLES-1 without a clear.
module awg_gap_timer #(
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // A byte in the expiry cycle wins: clear suppresses the pulse.
  assign expire = run && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/awg_cmd_ctrl.sv
// Frame-level command controller: assembles HEADER/CMD/AMP/SUM frames, validates them and
// hands accepted settings to the waveform datapath, stalling the receiver until acked.
module awg_cmd_ctrl
  import awg_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER         = AWG_HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 500_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  awg_cmd_if.master  bus,
  output awg_state_t state_dbg
);

  awg_state_t state, state_next;
  logic [7:0] cmd_sh, amp_sh;
  logic       cap_cmd, cap_amp, drop_shadow, load_cfg, err_event;
  logic       frame_ok, timer_run, timer_expire;

  logic       rx_en_q, cfg_valid_q, frame_err_q;
  logic [1:0] wave_q;
  logic [3:0] freq_q;
  logic [7:0] amp_q, err_cnt_q;

  assign timer_run = (state == ST_CMD) || (state == ST_AMP) || (state == ST_SUM);

  awg_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk    (CLK),
    .rst_n  (RSTn),
    .clear  (bus.RX_Done_Sig),
    .run    (timer_run),
    .expire (timer_expire)
  );

  assign frame_ok = (bus.RX_Data == awg_checksum(HEADER, cmd_sh, amp_sh)) &&
                    (cmd_sh[CMD_RSV_HI:CMD_RSV_LO] == 2'b00);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_HDR;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cap_cmd     = 1'b0;
    cap_amp     = 1'b0;
    drop_shadow = 1'b0;
    load_cfg    = 1'b0;
    err_event   = 1'b0;
    case (state)
      ST_HDR: begin
        if (bus.RX_Done_Sig && (bus.RX_Data == HEADER)) state_next = ST_CMD;
      end
      ST_CMD: begin
        if (bus.RX_Done_Sig) begin
          cap_cmd    = 1'b1;
          state_next = ST_AMP;
        end else if (timer_expire) begin
          err_event   = 1'b1;
          drop_shadow = 1'b1;
          state_next  = ST_HDR;
        end
      end
      ST_AMP: begin
        if (bus.RX_Done_Sig) begin
          cap_amp    = 1'b1;
          state_next = ST_SUM;
        end else if (timer_expire) begin
          err_event   = 1'b1;
          drop_shadow = 1'b1;
          state_next  = ST_HDR;
        end
      end
      ST_SUM: begin
        // The SUM byte is always consumed as a checksum, even if it equals HEADER.
        if (bus.RX_Done_Sig) begin
          if (frame_ok) begin
            load_cfg   = 1'b1;
            state_next = ST_PEND;
          end else begin
            err_event  = 1'b1;
            state_next = ST_HDR;
          end
        end else if (timer_expire) begin
          err_event   = 1'b1;
          drop_shadow = 1'b1;
          state_next  = ST_HDR;
        end
      end
      ST_PEND: begin
        if (bus.Cfg_Ack) state_next = ST_HDR;
      end
      default: state_next = ST_HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cmd_sh <= '0;
      amp_sh <= '0;
    end else if (drop_shadow) begin
      cmd_sh <= '0;
      amp_sh <= '0;
    end else begin
      if (cap_cmd) cmd_sh <= bus.RX_Data;
      if (cap_amp) amp_sh <= bus.RX_Data;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_en_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      wave_q      <= '0;
      freq_q      <= '0;
      amp_q       <= '0;
    end else begin
      rx_en_q     <= (state_next != ST_PEND);
      frame_err_q <= err_event;
      if (err_event && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (load_cfg) begin
        wave_q      <= {cmd_sh[CMD_WT1_BIT], cmd_sh[CMD_WT0_BIT]};
        freq_q      <= {cmd_sh[CMD_FS3_BIT], cmd_sh[CMD_FS2_BIT],
                        cmd_sh[CMD_FS1_BIT], cmd_sh[CMD_FS0_BIT]};
        amp_q       <= amp_sh;
        cfg_valid_q <= 1'b1;
      end else if ((state == ST_PEND) && bus.Cfg_Ack) begin
        cfg_valid_q <= 1'b0;
      end
    end
  end

  assign bus.RX_En_Sig = rx_en_q;
  assign bus.Cfg_Valid = cfg_valid_q;
  assign bus.Frame_Err = frame_err_q;
  assign bus.Err_Cnt   = err_cnt_q;
  assign bus.Wave_Type = wave_q;
  assign bus.Freq_Set  = freq_q;
  assign bus.Amp_Code  = amp_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Testbench for awg_cmd_ctrl: directed scenarios plus randomized frames checked against
// a frame-level reference model (accept rule, field decode, saturating error count).
module tb_awg_cmd_ctrl;
  import awg_cmd_pkg::*;

  localparam int         TO  = 16;
  localparam logic [7:0] HDR = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  awg_state_t state_dbg;

  awg_cmd_if bus();

  awg_cmd_ctrl #(.HEADER(HDR), .TIMEOUT_CYCLES(TO)) dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {Wave_Type, Freq_Set, Amp_Code} of each accepted frame.
  logic [13:0] exp_q[$];
  logic [1:0]  m_wave;
  logic [3:0]  m_freq;
  logic [7:0]  m_amp;
  int          m_err;

  function automatic bit ref_accept(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    return (s == (HDR ^ c ^ a)) && (c[7:6] == 2'b00);
  endfunction

  function automatic logic [13:0] ref_decode(input logic [7:0] c, input logic [7:0] a);
    return {c[0], c[1], c[2], c[3], c[4], c[5], a};
  endfunction

  function automatic logic [24:0] obs_vec();
    return {bus.Cfg_Valid, bus.RX_En_Sig, bus.Frame_Err, bus.Wave_Type, bus.Freq_Set,
            bus.Amp_Code, bus.Err_Cnt};
  endfunction

  function automatic logic [24:0] exp_vec(input logic cv, input logic en, input logic fe);
    return {cv, en, fe, m_wave, m_freq, m_amp, 8'(m_err)};
  endfunction

  task automatic model_reset();
    m_wave = '0; m_freq = '0; m_amp = '0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    logic [13:0] d;
    if (ref_accept(c, a, s)) begin
      d = ref_decode(c, a);
      {m_wave, m_freq, m_amp} = d;
      exp_q.push_back(d);
    end else begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end
  endtask

  // ---- drivers ----
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.RX_Data     = b;
    bus.RX_Done_Sig = 1'b1;
    @(negedge clk);
    bus.RX_Done_Sig = 1'b0;
    bus.RX_Data     = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    send_byte(HDR);
    send_byte(c);
    send_byte(a);
    model_frame(c, a, s);
    send_byte(s);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    bus.Cfg_Ack = 1'b1;
    @(negedge clk);
    bus.Cfg_Ack = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    idle(3);
    checks++;
    if (obs_vec() !== 25'd0 || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL reset_values: got %h state %0d, expected 0000000 state 0", obs_vec(), state_dbg);
    end
    rst_n = 1'b1;
    checks++;
    if (bus.RX_En_Sig !== 1'b0) begin
      errors++;
      $display("FAIL rx_en_before_edge: got %b expected 0", bus.RX_En_Sig);
    end
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL rx_en_after_release: got %h expected %h", obs_vec(), exp_vec(1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_valid_frame();
    logic [13:0] e;
    send_frame(8'h15, 8'h80, 8'h3F);
    e = exp_q.pop_front();
    checks++;
    if ({bus.Wave_Type, bus.Freq_Set, bus.Amp_Code} !== {2'b10, 4'b1010, 8'h80} ||
        {bus.Wave_Type, bus.Freq_Set, bus.Amp_Code} !== e) begin
      errors++;
      $display("FAIL valid_decode: got %h expected %h", {bus.Wave_Type, bus.Freq_Set, bus.Amp_Code}, e);
    end
    checks++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0, 1'b0) || state_dbg !== ST_PEND) begin
      errors++;
      $display("FAIL valid_pending: got %h state %0d expected %h state 4", obs_vec(), state_dbg,
               exp_vec(1'b1, 1'b0, 1'b0));
    end
    do_ack(2);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b0) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL valid_ack: got %h state %0d expected %h state 0", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_bad_checksum();
    send_frame(8'h15, 8'h80, 8'h00);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b1) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL bad_sum_err: got %h state %0d expected %h state 0", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b1));
    end
    @(negedge clk);
    checks++;
    if (bus.Frame_Err !== 1'b0) begin
      errors++;
      $display("FAIL bad_sum_pulse_width: got %b expected 0", bus.Frame_Err);
    end
    // A SUM byte equal to HEADER must not start a new frame; the trailing bytes are noise.
    send_frame(8'h15, 8'h80, HDR);
    send_byte(8'h15);
    send_byte(8'h80);
    send_byte(8'h3F);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b0) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL sum_is_header: got %h state %0d expected %h state 0", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_reserved();
    send_frame(8'hC0, 8'h00, 8'h6A);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b1) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL reserved_bits: got %h state %0d expected %h state 0", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b1));
    end
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    send_byte(HDR);
    send_byte(8'h15);
    idle(TO - 1);
    checks++;
    if (bus.Frame_Err !== 1'b0 || state_dbg !== ST_AMP) begin
      errors++;
      $display("FAIL timeout_early: frame_err %b state %0d expected 0 state 2", bus.Frame_Err, state_dbg);
    end
    m_err = (m_err < 255) ? m_err + 1 : 255;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b1) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL timeout_expire: got %h state %0d expected %h state 0", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b1));
    end
    send_frame(8'h2A, 8'h33, 8'hB3);
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0, 1'b0) || {bus.Wave_Type, bus.Freq_Set, bus.Amp_Code} !== e) begin
      errors++;
      $display("FAIL timeout_recover: got %h expected %h", obs_vec(), exp_vec(1'b1, 1'b0, 1'b0));
    end
    do_ack(0);
  endtask

  task automatic test_noise_stall();
    logic [13:0] e;
    send_byte(8'h00);
    send_byte(8'h55);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b0) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL noise_ignored: got %h state %0d expected %h state 0", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b0));
    end
    send_frame(8'h0B, 8'h7F, HDR ^ 8'h0B ^ 8'h7F);
    e = exp_q.pop_front();
    send_byte(HDR);
    send_byte(8'h15);
    send_byte(8'h80);
    send_byte(8'h3F);
    checks++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0, 1'b0) || {bus.Wave_Type, bus.Freq_Set, bus.Amp_Code} !== e ||
        state_dbg !== ST_PEND) begin
      errors++;
      $display("FAIL pend_stall: got %h state %0d expected %h state 4", obs_vec(), state_dbg,
               exp_vec(1'b1, 1'b0, 1'b0));
    end
    do_ack(1);
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b0) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL stall_release: got %h state %0d expected %h", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    bus.Cfg_Ack = 1'b1;
    idle(2);
    send_frame(8'h3E, 8'h01, HDR ^ 8'h3E ^ 8'h01);
    void'(exp_q.pop_front());
    checks++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL b2b_first_pend: got %h expected %h", obs_vec(), exp_vec(1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
    bus.Cfg_Ack = 1'b0;
    checks++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b0) || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL b2b_min_pend: got %h state %0d expected %h", obs_vec(), state_dbg,
               exp_vec(1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [7:0]  c, a, s, n;
    logic [13:0] e;
    bit          acc;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        n = 8'($urandom);
        if (n == HDR) n = 8'h00;
        send_byte(n);
      end
      c = 8'($urandom);
      if ($urandom_range(0, 3) != 0) c[7:6] = 2'b00;
      a = 8'($urandom);
      s = ($urandom_range(0, 3) != 0) ? (HDR ^ c ^ a) : 8'($urandom);
      acc = ref_accept(c, a, s);
      send_frame(c, a, s);
      checks++;
      if (obs_vec() !== exp_vec(acc, !acc, !acc)) begin
        errors++;
        $display("FAIL rand_frame[%0d]: got %h expected %h", i, obs_vec(), exp_vec(acc, !acc, !acc));
      end
      if (acc) begin
        e = exp_q.pop_front();
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
        checks++;
        if ({bus.Wave_Type, bus.Freq_Set, bus.Amp_Code} !== e || bus.Cfg_Valid !== 1'b1) begin
          errors++;
          $display("FAIL rand_settings[%0d]: got %h valid %b expected %h", i,
                   {bus.Wave_Type, bus.Freq_Set, bus.Amp_Code}, bus.Cfg_Valid, e);
        end
        do_ack($urandom_range(0, 3));
        checks++;
        if (bus.Cfg_Valid !== 1'b0 || bus.RX_En_Sig !== 1'b1 || state_dbg !== ST_HDR) begin
          errors++;
          $display("FAIL rand_ack[%0d]: valid %b en %b state %0d expected 0 1 0", i,
                   bus.Cfg_Valid, bus.RX_En_Sig, state_dbg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    send_byte(HDR);
    send_byte(8'h15);
    checks++;
    if (state_dbg !== ST_AMP) begin
      errors++;
      $display("FAIL reset_mid_setup: state %0d expected 2", state_dbg);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 25'd0 || state_dbg !== ST_HDR) begin
      errors++;
      $display("FAIL reset_mid: got %h state %0d expected 0000000 state 0", obs_vec(), state_dbg);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h80);
    send_byte(8'h3F);
    send_frame(8'h21, 8'hC4, HDR ^ 8'h21 ^ 8'hC4);
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0, 1'b0) || {bus.Wave_Type, bus.Freq_Set, bus.Amp_Code} !== e) begin
      errors++;
      $display("FAIL reset_mid_recover: got %h expected %h", obs_vec(), exp_vec(1'b1, 1'b0, 1'b0));
    end
    do_ack(0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h15, 8'h80, 8'h00);
      if (i == 254 || i == 299) begin
        checks++;
        if (obs_vec() !== exp_vec(1'b0, 1'b1, 1'b1) || bus.Err_Cnt !== 8'd255) begin
          errors++;
          $display("FAIL err_saturate[%0d]: got %h err_cnt %0d expected %h err_cnt 255", i,
                   obs_vec(), bus.Err_Cnt, exp_vec(1'b0, 1'b1, 1'b1));
        end
      end
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RX_Done_Sig = 1'b0;
    bus.RX_Data     = 8'h00;
    bus.Cfg_Ack     = 1'b0;
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_reserved();
    test_timeout();
    test_noise_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
